// File: rtl/sev_crypt_engine.sv
// Multi-VM memory encryption engine: per-VM key table, address-tweaked keystream plus rotate,
// two-stage valid/ready pipeline (S1 key lookup, S2 transform and output register).
module sev_crypt_engine #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 48,
    parameter int NUM_VMS = 16,
    parameter int TAG_W   = 8,
    parameter int ROT     = 13,
    localparam int VM_W   = (NUM_VMS > 1) ? $clog2(NUM_VMS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              key_we_i,
    input  logic              key_clr_i,
    input  logic [VM_W-1:0]   key_vm_i,
    input  logic [DATA_W-1:0] key_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_enc_i,
    input  logic [VM_W-1:0]   req_vm_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic [TAG_W-1:0]  rsp_tag_o
);

    logic [DATA_W-1:0] key_mem [NUM_VMS];
    logic [NUM_VMS-1:0] key_vld;

    logic              s1_valid;
    logic              s1_enc;
    logic              s1_err;
    logic [DATA_W-1:0] s1_ks;
    logic [DATA_W-1:0] s1_data;
    logic [TAG_W-1:0]  s1_tag;

    logic              s1_adv;
    logic              s2_adv;
    logic              req_fire;
    logic              req_in_range;
    logic              key_in_range;
    logic [DATA_W-1:0] lk_key;
    logic              lk_vld;
    logic [DATA_W-1:0] enc_x;
    logic [DATA_W-1:0] enc_out;
    logic [DATA_W-1:0] dec_out;

    assign s2_adv      = !rsp_valid_o || rsp_ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign req_ready_o = s1_adv;
    assign req_fire    = req_valid_i && s1_adv;

    assign req_in_range = 32'(req_vm_i) < NUM_VMS;
    assign key_in_range = 32'(key_vm_i) < NUM_VMS;

    // Out-of-range ids never index the table; they read as keyless.
    always_comb begin
        lk_key = '0;
        lk_vld = 1'b0;
        if (req_in_range) begin
            lk_key = key_mem[req_vm_i];
            lk_vld = key_vld[req_vm_i];
        end
    end

    always_comb begin
        enc_x   = s1_data ^ s1_ks;
        enc_out = (enc_x << ROT) | (enc_x >> (DATA_W - ROT));
        dec_out = ((s1_data >> ROT) | (s1_data << (DATA_W - ROT))) ^ s1_ks;
    end

    // Table updates land at the same edge a request samples it, so that request sees the old entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            key_vld <= '0;
            for (int i = 0; i < NUM_VMS; i++) begin
                key_mem[i] <= '0;
            end
        end else if (key_in_range) begin
            if (key_we_i) begin
                key_mem[key_vm_i] <= key_i;
                key_vld[key_vm_i] <= 1'b1;
            end else if (key_clr_i) begin
                key_vld[key_vm_i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_enc   <= 1'b0;
            s1_err   <= 1'b0;
            s1_ks    <= '0;
            s1_data  <= '0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= req_valid_i;
            if (req_fire) begin
                s1_enc  <= req_enc_i;
                s1_err  <= !req_in_range || !lk_vld;
                s1_ks   <= lk_key ^ DATA_W'(req_addr_i);
                s1_data <= req_data_i;
                s1_tag  <= req_tag_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= '0;
            rsp_tag_o   <= '0;
        end else if (s2_adv) begin
            rsp_valid_o <= s1_valid;
            if (s1_valid) begin
                rsp_err_o  <= s1_err;
                rsp_tag_o  <= s1_tag;
                rsp_data_o <= s1_err ? '0 : (s1_enc ? enc_out : dec_out);
            end
        end
    end

endmodule

// File: tb/tb_sev_crypt_engine.sv
// Scoreboard bench for sev_crypt_engine: driver pushes expected responses at acceptance,
// an independent monitor pops and compares on every response handshake.
module tb_sev_crypt_engine;

    localparam int NVM = 12;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        key_we_i, key_clr_i;
    logic [3:0]  key_vm_i;
    logic [63:0] key_i;
    logic        req_valid_i, req_ready_o, req_enc_i;
    logic [3:0]  req_vm_i;
    logic [47:0] req_addr_i;
    logic [63:0] req_data_i;
    logic [7:0]  req_tag_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [63:0] rsp_data_o;
    logic [7:0]  rsp_tag_o;

    sev_crypt_engine #(.NUM_VMS(NVM)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .key_we_i(key_we_i), .key_clr_i(key_clr_i), .key_vm_i(key_vm_i), .key_i(key_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_enc_i(req_enc_i),
        .req_vm_i(req_vm_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .rsp_tag_o(rsp_tag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        err;
        logic [63:0] data;
        logic [7:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready  = 0;
    bit   force_ready = 1;
    bit   nobubble    = 0;

    logic [63:0] m_key [16];
    bit          m_vld [16];
    logic [63:0] pt    [64];
    logic [63:0] ct    [64];
    logic [3:0]  svm   [64];
    logic [47:0] sadr  [64];
    bit          serr  [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rotl13(input logic [63:0] x);
        return (x << 13) | (x >> 51);
    endfunction

    function automatic bit m_err(input logic [3:0] vm);
        return (int'(vm) >= NVM) || !m_vld[vm];
    endfunction

    function automatic logic [63:0] m_enc(input logic [3:0] vm, input logic [47:0] a,
                                          input logic [63:0] d);
        return rotl13(d ^ m_key[vm] ^ {16'h0, a});
    endfunction

    always @(posedge clk_i) begin
        #1;
        rsp_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end

    // Monitor: pops on every response handshake, checks outputs hold while stalled.
    bit          prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_err;
    logic [7:0]  prev_tag;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(rsp_valid_o), 64'd1);
                check("stall_data", rsp_data_o, prev_data);
                check("stall_errtag", {55'd0, rsp_err_o, rsp_tag_o}, {55'd0, prev_err, prev_tag});
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'({rsp_err_o, rsp_tag_o}), 64'h1ff_0000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
                    check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    check("rsp_data", rsp_data_o, e.data);
                end
            end
            prev_stall = rsp_valid_o && !rsp_ready_i;
            prev_data  = rsp_data_o;
            prev_err   = rsp_err_o;
            prev_tag   = rsp_tag_o;
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input bit enc, input logic [3:0] vm, input logic [47:0] a,
                        input logic [63:0] d, input logic [7:0] tag,
                        input bit err, input logic [63:0] exp_d);
        int   waitc = 0;
        exp_t e;
        req_valid_i = 1; req_enc_i = enc; req_vm_i = vm;
        req_addr_i = a; req_data_i = d; req_tag_i = tag;
        if (nobubble) check("no_bubble_ready", 64'(req_ready_o), 64'd1);
        while (!req_ready_o && waitc < 200) begin
            @(negedge clk_i);
            waitc++;
        end
        if (!req_ready_o) begin
            check("req_ready_timeout", 64'(req_ready_o), 64'd1);
        end else begin
            e.err = err; e.data = err ? 64'd0 : exp_d; e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk_i);
        req_valid_i = 0;
    endtask

    task automatic key_op(input bit we, input bit clr, input logic [3:0] vm, input logic [63:0] k);
        key_we_i = we; key_clr_i = clr; key_vm_i = vm; key_i = k;
        @(negedge clk_i);
        key_we_i = 0; key_clr_i = 0;
        if (int'(vm) < NVM) begin
            if (we) begin m_key[vm] = k; m_vld[vm] = 1; end
            else if (clr) m_vld[vm] = 0;
        end
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge clk_i);
            c++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_ni = 0; key_we_i = 0; key_clr_i = 0; key_vm_i = 0; key_i = 0;
        req_valid_i = 0; req_enc_i = 0; req_vm_i = 0; req_addr_i = 0; req_data_i = 0;
        req_tag_i = 0; rsp_ready_i = 1;
        for (int i = 0; i < 16; i++) begin m_key[i] = 0; m_vld[i] = 0; end
        repeat (3) @(negedge clk_i);
        check("reset_valid", 64'(rsp_valid_o), 64'd0);
        check("reset_err", 64'(rsp_err_o), 64'd0);
        check("reset_data", rsp_data_o, 64'd0);
        check("reset_tag", 64'(rsp_tag_o), 64'd0);
        rst_ni = 1;
        @(negedge clk_i);

        // 1: no key -> error, 2-cycle latency
        send(1, 4'd0, 48'd0, 64'h5, 8'h11, 1, 64'd0);
        check("lat_not_early", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        check("lat_valid", 64'(rsp_valid_o), 64'd1);
        check("lat_err", 64'(rsp_err_o), 64'd1);
        drain();

        // 2 and 3: hand-computed vectors, zero key legal once installed
        key_op(1, 0, 4'd1, 64'h1);
        send(1, 4'd1, 48'd0, 64'd0, 8'h21, 0, 64'h2000);
        send(0, 4'd1, 48'd0, 64'h2000, 8'h22, 0, 64'h0);
        key_op(1, 0, 4'd2, 64'h0);
        send(1, 4'd2, 48'h1000, 64'd0, 8'h31, 0, 64'h0000_0000_0200_0000);
        key_op(1, 1, 4'd4, 64'h77);
        send(1, 4'd4, 48'd0, 64'd0, 8'h41, 0, 64'hEE000);
        key_op(1, 0, 4'd13, 64'h99);
        send(1, 4'd13, 48'd0, 64'd0, 8'h42, 1, 64'd0);
        drain();

        // 5: same-cycle key write sees old key; clear -> error
        key_op(1, 0, 4'd3, 64'h55);
        key_we_i = 1; key_vm_i = 4'd3; key_i = 64'hAA;
        send(1, 4'd3, 48'h10, 64'd0, 8'h51, 0, 64'h8A000);
        key_we_i = 0;
        m_key[3] = 64'hAA;
        send(1, 4'd3, 48'h10, 64'd0, 8'h52, 0, 64'h174000);
        key_op(0, 1, 4'd3, 64'd0);
        send(1, 4'd3, 48'h10, 64'd0, 8'h53, 1, 64'd0);
        drain();

        // 4: random stream under random backpressure, then decrypt round trip
        for (int v = 0; v < 8; v++) key_op(1, 0, 4'(v), {$urandom, $urandom});
        for (int v = 8; v < NVM; v++) key_op(0, 1, 4'(v), 64'd0);
        rand_ready = 1;
        for (int i = 0; i < 64; i++) begin
            svm[i]  = 4'($urandom_range(0, 15));
            sadr[i] = {$urandom, $urandom}[47:0];
            pt[i]   = {$urandom, $urandom};
            serr[i] = m_err(svm[i]);
            ct[i]   = m_enc(svm[i], sadr[i], pt[i]);
            send(1, svm[i], sadr[i], pt[i], 8'(i), serr[i], ct[i]);
        end
        for (int i = 0; i < 64; i++)
            send(0, svm[i], sadr[i], ct[i], 8'(i + 64), serr[i], pt[i]);
        rand_ready = 0; force_ready = 1;
        @(negedge clk_i);
        drain();
        nobubble = 1;
        for (int i = 0; i < 16; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            send(1, 4'(i % 8), 48'(i * 64), d, 8'(i + 128), 0, m_enc(4'(i % 8), 48'(i * 64), d));
        end
        nobubble = 0;
        drain();

        // 6: reset with pipeline full and stalled
        force_ready = 0;
        repeat (2) @(negedge clk_i);
        send(1, 4'd0, 48'd0, 64'd1, 8'h61, 0, 64'd0);
        send(1, 4'd0, 48'd0, 64'd2, 8'h62, 0, 64'd0);
        check("full_stalled_ready", 64'(req_ready_o), 64'd0);
        rst_ni = 0;
        sb.delete();
        @(negedge clk_i);
        check("rst_valid_clear", 64'(rsp_valid_o), 64'd0);
        rst_ni = 1;
        force_ready = 1;
        repeat (3) @(negedge clk_i);
        check("rst_s1_dropped", 64'(rsp_valid_o), 64'd0);
        for (int i = 0; i < 16; i++) m_vld[i] = 0;
        send(1, 4'd1, 48'd0, 64'd0, 8'h71, m_err(4'd1), 64'd0);
        send(1, 4'd4, 48'd0, 64'd0, 8'h72, 1, 64'd0);
        send(0, 4'd15, 48'd0, 64'd0, 8'h73, 1, 64'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
